// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receive-engine state encoding and default timing
// constants used by both the controller and the byte receiver.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BITS,
        ACK_WAIT,
        ACK
    } rx_state_t;

    localparam int unsigned BYTE_BITS      = 8;
    localparam int unsigned FILTER_LEN_DEF = 4;   // 80 ns at 50 MHz
    localparam int unsigned HOLD_CYC_DEF   = 15;  // 300 ns SDA hold at 50 MHz

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output only
// follows the input after FILTER_LEN consecutive differing samples.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic CLK,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            sync <= 2'b11;
            cnt  <= '0;
            dout <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_byte_rx.sv
// I2C receive byte engine: conditions SCL/SDA, detects START/STOP, shifts in
// bytes MSB first and drives the ninth-bit ACK/NACK with a fixed hold time.
module i2c_byte_rx
    import i2c_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
    parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 scl_in,
    input  logic                 sda_in,
    input  logic                 rx_en,
    input  logic                 ack_en,
    output logic                 sda_oe,
    output logic [BYTE_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 start_det,
    output logic                 stop_det,
    output logic                 busy
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int unsigned CNT_W  = 4;

    logic scl_f, sda_f, scl_fd, sda_fd;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_c, stop_c;

    rx_state_t            state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [BYTE_BITS-1:0] shreg, shreg_nxt;
    logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
    logic                 ack_lat, ack_lat_nxt;
    logic                 sda_oe_nxt, rx_valid_nxt, busy_nxt;
    logic [BYTE_BITS-1:0] rx_data_nxt;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .CLK  (CLK),
        .rst  (rst),
        .din  (scl_in),
        .dout (scl_f)
    );

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .CLK  (CLK),
        .rst  (rst),
        .din  (sda_in),
        .dout (sda_f)
    );

    // One-cycle edge strobes off the filtered lines
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            scl_fd   <= 1'b1;
            sda_fd   <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            sda_rise <= 1'b0;
            sda_fall <= 1'b0;
        end else begin
            scl_fd   <= scl_f;
            sda_fd   <= sda_f;
            scl_rise <= scl_f & ~scl_fd;
            scl_fall <= ~scl_f & scl_fd;
            sda_rise <= sda_f & ~sda_fd;
            sda_fall <= ~sda_f & sda_fd;
        end
    end

    // Bus conditions are ignored while we drive SDA ourselves or are disabled
    assign start_c = rx_en & ~sda_oe & sda_fall & scl_f;
    assign stop_c  = rx_en & ~sda_oe & sda_rise & scl_f;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold_cnt  <= '0;
            ack_lat   <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            hold_cnt  <= hold_nxt;
            ack_lat   <= ack_lat_nxt;
            sda_oe    <= sda_oe_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            start_det <= start_c;
            stop_det  <= stop_c;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        hold_nxt     = hold_cnt;
        ack_lat_nxt  = ack_lat;
        sda_oe_nxt   = sda_oe;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        busy_nxt     = busy;

        if (!rx_en || stop_c) begin
            state_nxt  = IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
            hold_nxt   = '0;
        end else if (start_c) begin
            // START or repeated START always restarts the byte
            state_nxt   = BITS;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b1;
            hold_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    sda_oe_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
                BITS: begin
                    if (scl_rise) begin
                        shreg_nxt = {shreg[BYTE_BITS-2:0], sda_f};
                        if (bit_cnt < CNT_W'(BYTE_BITS)) begin
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                        if (bit_cnt == CNT_W'(BYTE_BITS - 1)) begin
                            rx_data_nxt  = {shreg[BYTE_BITS-2:0], sda_f};
                            rx_valid_nxt = 1'b1;
                            ack_lat_nxt  = ack_en;
                            state_nxt    = ACK_WAIT;
                        end
                    end
                end
                ACK_WAIT: begin
                    if (scl_fall) begin
                        hold_nxt = HOLD_W'(HOLD_CYC);
                    end else if (hold_cnt == HOLD_W'(1)) begin
                        hold_nxt   = '0;
                        sda_oe_nxt = ack_lat;
                        state_nxt  = ACK;
                    end else if (hold_cnt != '0) begin
                        hold_nxt = hold_cnt - HOLD_W'(1);
                    end
                end
                ACK: begin
                    // The ninth rising edge needs no action; release after its fall
                    if (scl_fall) begin
                        hold_nxt = HOLD_W'(HOLD_CYC);
                    end else if (hold_cnt == HOLD_W'(1)) begin
                        hold_nxt    = '0;
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        state_nxt   = BITS;
                    end else if (hold_cnt != '0) begin
                        hold_nxt = hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    sda_oe_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule
